// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way write-back/write-allocate L1, with saturating perf counters.
// Latency: hit answers in the lookup cycle; clean miss 3 cycles min, dirty miss 4 min.
// Backpressure: the CPU holds its request until mem_resp; pmem strobes hold until pmem_resp.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           hit,
    input  logic                 lru_out,
    input  logic                 dirty_mux_out,
    input  logic                 pmem_resp,
    input  logic                 perf_clear,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 tag_write,
    output logic                 valid_write,
    output logic                 dc_mem_write,
    output logic                 dirty_set,
    output logic                 dirty_reset,
    output logic                 lru_write,
    output logic                 retain,
    output logic                 pmem_addr_sel,
    output logic                 save_to_cache_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 miss_pend_q, miss_pend_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

    logic req, any_hit, is_write, hit_way;
    logic lookup_hit, lookup_miss;

    // A simultaneous read+write is serviced as a write; hit==11 resolves to way 1.
    assign req         = mem_read | mem_write;
    assign is_write    = mem_write;
    assign any_hit     = hit[0] | hit[1];
    assign hit_way     = hit[1];
    assign lookup_hit  = (state_q == COMPARE) && req && any_hit;
    assign lookup_miss = (state_q == COMPARE) && req && !any_hit;

    // State, miss-pending flag and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COMPARE;
            miss_pend_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            miss_pend_q <= miss_pend_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    // Next state; a withdrawn request still lets the pmem transaction finish.
    always_comb begin
        state_d     = state_q;
        miss_pend_d = miss_pend_q;
        case (state_q)
            COMPARE: begin
                if (lookup_hit) begin
                    miss_pend_d = 1'b0;
                end else if (lookup_miss) begin
                    miss_pend_d = 1'b1;
                    state_d     = dirty_mux_out ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (pmem_resp) state_d = ALLOCATE;
            ALLOCATE:  if (pmem_resp) state_d = COMPARE;
            default:   state_d = COMPARE;
        endcase
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (perf_clear) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            wb_cnt_d   = '0;
        end else begin
            if (lookup_hit && !miss_pend_q && hit_cnt_q != '1)
                hit_cnt_d = hit_cnt_q + CNT_ONE;
            if (lookup_miss && miss_cnt_q != '1)
                miss_cnt_d = miss_cnt_q + CNT_ONE;
            if (lookup_miss && dirty_mux_out && wb_cnt_q != '1)
                wb_cnt_d = wb_cnt_q + CNT_ONE;
        end
    end

    // Datapath strobes; everything is forced low while reset is held.
    always_comb begin
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        tag_write         = 1'b0;
        valid_write       = 1'b0;
        dc_mem_write      = 1'b0;
        dirty_set         = 1'b0;
        dirty_reset       = 1'b0;
        lru_write         = 1'b0;
        retain            = 1'b0;
        pmem_addr_sel     = 1'b0;
        save_to_cache_sel = 1'b0;
        if (!reset) begin
            case (state_q)
                COMPARE: begin
                    if (lookup_hit) begin
                        mem_resp  = 1'b1;
                        lru_write = (hit_way == lru_out);
                        if (is_write) begin
                            dc_mem_write      = 1'b1;
                            dirty_set         = 1'b1;
                            save_to_cache_sel = 1'b1;
                        end
                    end else if (lookup_miss && dirty_mux_out) begin
                        retain = 1'b1;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        tag_write   = 1'b1;
                        valid_write = 1'b1;
                        dirty_reset = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

    // Both ways matching the same tag means the datapath is corrupt.
    hit_onehot_a: assert property (@(posedge clk) disable iff (reset)
        !((state_q == COMPARE) && req && (hit == 2'b11)));

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write;
    logic [1:0]    hit;
    logic          lru_out, dirty_mux_out, pmem_resp, perf_clear;
    logic          mem_resp, pmem_read, pmem_write, tag_write, valid_write;
    logic          dc_mem_write, dirty_set, dirty_reset, lru_write, retain;
    logic          pmem_addr_sel, save_to_cache_sel;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .lru_out(lru_out), .dirty_mux_out(dirty_mux_out),
        .pmem_resp(pmem_resp), .perf_clear(perf_clear),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .tag_write(tag_write), .valid_write(valid_write),
        .dc_mem_write(dc_mem_write), .dirty_set(dirty_set),
        .dirty_reset(dirty_reset), .lru_write(lru_write), .retain(retain),
        .pmem_addr_sel(pmem_addr_sel), .save_to_cache_sel(save_to_cache_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Expected strobes when mem_resp fires: {lru_write, dc_mem_write, dirty_set, save_to_cache_sel}
    logic [3:0] resp_q[$];
    // Expected strobes when tag_write fires: {valid_write, dirty_reset, save_sel, pmem_read, addr_sel}
    logic [4:0] fill_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int h, input int m, input int w);
        chk({tag, "_hit_count"}, int'(hit_count), h);
        chk({tag, "_miss_count"}, int'(miss_count), m);
        chk({tag, "_wb_count"}, int'(wb_count), w);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a request or installs a fill.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_resp) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_mem_resp", 1, 0);
                end else begin
                    logic [3:0] e;
                    e = resp_q.pop_front();
                    chk("resp_strobes",
                        int'({lru_write, dc_mem_write, dirty_set, save_to_cache_sel}), int'(e));
                    chk("resp_no_pmem", int'({pmem_read, pmem_write}), 0);
                end
            end
            if (tag_write) begin
                if (fill_q.size() == 0) begin
                    chk("unexpected_tag_write", 1, 0);
                end else begin
                    logic [4:0] f;
                    f = fill_q.pop_front();
                    chk("fill_strobes",
                        int'({valid_write, dirty_reset, save_to_cache_sel, pmem_read, pmem_addr_sel}),
                        int'(f));
                end
            end
        end
    end

    // One clean read miss: allocate with immediate pmem_resp, then re-lookup hit in way 0.
    task automatic clean_miss();
        mem_read = 1'b1; hit = 2'b00; dirty_mux_out = 1'b0; lru_out = 1'b0;
        cyc();
        pmem_resp = 1'b1; fill_q.push_back(5'b11010);
        cyc();
        pmem_resp = 1'b0; hit = 2'b01; resp_q.push_back(4'b1000);
        cyc();
        mem_read = 1'b0; hit = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        lru_out = 1'b0; dirty_mux_out = 1'b0; pmem_resp = 1'b0; perf_clear = 1'b0;
        cyc();
        // Outputs stay low under reset even with a hitting request present.
        mem_read = 1'b1; hit = 2'b01;
        #1;
        chk("reset_mem_resp", int'(mem_resp), 0);
        chk("reset_lru_write", int'(lru_write), 0);
        chk_cnt("reset", 0, 0, 0);
        mem_read = 1'b0; hit = 2'b00;
        cyc();
        reset = 1'b0;
        cyc();

        // Read hit in way 0 which is LRU: LRU flips.
        mem_read = 1'b1; hit = 2'b01; lru_out = 1'b0; resp_q.push_back(4'b1000);
        cyc();
        mem_read = 1'b0; hit = 2'b00;
        chk("rd_hit_pmem_read", int'(pmem_read), 0);
        chk_cnt("rd_hit", 1, 0, 0);

        // Write hit in way 1 while LRU is way 0: no LRU update, merge+dirty.
        mem_write = 1'b1; hit = 2'b10; lru_out = 1'b0; resp_q.push_back(4'b0111);
        cyc();
        mem_write = 1'b0; hit = 2'b00;
        chk_cnt("wr_hit", 2, 0, 0);

        // Clean read miss with a 5-cycle memory wait.
        mem_read = 1'b1; dirty_mux_out = 1'b0;
        #1;
        chk("clean_retain", int'(retain), 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("clean_pmem_read", int'(pmem_read), 1);
            cyc();
        end
        pmem_resp = 1'b1; fill_q.push_back(5'b11010);
        cyc();
        pmem_resp = 1'b0; hit = 2'b01; lru_out = 1'b0; resp_q.push_back(4'b1000);
        cyc();
        mem_read = 1'b0; hit = 2'b00;
        chk_cnt("clean_miss", 2, 1, 0);

        // Dirty write miss: retain, writeback from victim address, then fill.
        mem_write = 1'b1; hit = 2'b00; dirty_mux_out = 1'b1; lru_out = 1'b1;
        #1;
        chk("dirty_retain", int'(retain), 1);
        chk("dirty_no_pmem_write_yet", int'(pmem_write), 0);
        cyc();
        dirty_mux_out = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wb_pmem_write_addr_sel", int'({pmem_write, pmem_addr_sel, pmem_read}), 6);
            cyc();
        end
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        chk("alloc_pmem_read_addr_sel", int'({pmem_read, pmem_addr_sel, pmem_write}), 4);
        cyc();
        pmem_resp = 1'b1; fill_q.push_back(5'b11010);
        cyc();
        pmem_resp = 1'b0; hit = 2'b10; lru_out = 1'b1; resp_q.push_back(4'b1111);
        cyc();
        mem_write = 1'b0; hit = 2'b00;
        chk_cnt("dirty_miss", 2, 2, 1);

        // Reset in the middle of a line fill.
        mem_read = 1'b1; dirty_mux_out = 1'b0;
        cyc();
        chk("pre_reset_pmem_read", int'(pmem_read), 1);
        reset = 1'b1; hit = 2'b01;
        #1;
        chk("mid_reset_pmem_read", int'(pmem_read), 0);
        chk("mid_reset_mem_resp", int'(mem_resp), 0);
        chk_cnt("mid_reset", 0, 0, 0);
        cyc();
        lru_out = 1'b0; resp_q.push_back(4'b1000);
        reset = 1'b0;
        cyc();
        mem_read = 1'b0; hit = 2'b00;
        chk_cnt("post_reset", 1, 0, 0);

        // Request withdrawn during writeback: fill still installed, no mem_resp.
        mem_read = 1'b1; dirty_mux_out = 1'b1;
        cyc();
        mem_read = 1'b0; dirty_mux_out = 1'b0;
        chk("wd_pmem_write", int'(pmem_write), 1);
        cyc();
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        chk("wd_pmem_read", int'(pmem_read), 1);
        cyc();
        pmem_resp = 1'b1; fill_q.push_back(5'b11010);
        cyc();
        pmem_resp = 1'b0;
        chk("wd_idle_pmem", int'({pmem_read, pmem_write}), 0);
        cyc();
        cyc();
        chk_cnt("withdraw", 1, 1, 1);

        // Miss counter saturation at 2^CW-1.
        for (int i = 0; i < 14; i++) clean_miss();
        chk_cnt("sat_reach", 1, 15, 1);
        clean_miss();
        clean_miss();
        chk_cnt("sat_hold", 1, 15, 1);

        // A first-lookup hit counts, then clear wins over a same-cycle hit.
        mem_read = 1'b1; hit = 2'b01; lru_out = 1'b0; resp_q.push_back(4'b1000);
        cyc();
        chk("pre_clear_hit_count", int'(hit_count), 2);
        perf_clear = 1'b1; resp_q.push_back(4'b1000);
        cyc();
        perf_clear = 1'b0; mem_read = 1'b0; hit = 2'b00;
        chk_cnt("clear", 0, 0, 0);
        mem_read = 1'b1; hit = 2'b01; resp_q.push_back(4'b1000);
        cyc();
        mem_read = 1'b0; hit = 2'b00;
        chk_cnt("after_clear", 1, 0, 0);

        cyc();
        chk("resp_queue_drained", resp_q.size(), 0);
        chk("fill_queue_drained", fill_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
